ntt_layer_sequencer: RTL and testbench

Controls the Dilithium forward NTT over one 256-coefficient polynomial by driving a single pipelined butterfly unit. It generates coefficient and twiddle addresses for all 8 layers (len = 128 down to 1), aligns operands to the butterfly's internal pipeline, and writes u/v results back. Coefficients ping-pong between two external RAM banks from layer to layer. The block sits directly upstream of the butterfly and between it and the polynomial RAM / zeta ROM.

---
 rtl/ntt_layer_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_ntt_layer_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_layer_sequencer.sv
// ntt_layer_sequencer
// Address and operand sequencer for the Dilithium forward NTT of one
// 256-coefficient polynomial. It drives a single pipelined butterfly unit and
// ping-pongs the coefficients between two RAM banks from layer to layer.
// Optional feature: define NTT_SEQ_PERF_EN to add the cyc_cnt busy-cycle counter.
module ntt_layer_sequencer #(
   parameter int Q = 8380417,
   parameter int N = 256,
   localparam int DW = $clog2(Q),
   localparam int AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          src_bank,
   output logic [AW-1:0] rd_addr_j,
   output logic [AW-1:0] rd_addr_k,
   input  logic [DW-1:0] rd_data_j,
   input  logic [DW-1:0] rd_data_k,
   output logic [AW-1:0] zeta_idx,
   input  logic [DW-1:0] zeta_data,
   output logic [DW-1:0] bf_a,
   output logic [DW-1:0] bf_b,
   output logic [DW-1:0] bf_zeta,
   input  logic [DW-1:0] bf_u,
   input  logic [DW-1:0] bf_v,
`ifdef NTT_SEQ_PERF_EN
   output logic [10:0]   cyc_cnt,
`endif
   output logic          wr_en,
   output logic [AW-1:0] wr_addr_j,
   output logic [AW-1:0] wr_addr_k,
   output logic [DW-1:0] wr_data_j,
   output logic [DW-1:0] wr_data_k
);

   localparam int HALF = N / 2;
   localparam logic [AW-2:0] BCNT_LAST = (AW-1)'(HALF - 1);
   localparam logic [2:0] LAYER_LAST = 3'd7;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

   state_t        state, state_nxt;
   logic [2:0]    layer, layer_nxt;
   logic [AW-2:0] bcnt, bcnt_nxt;
   logic [1:0]    dcnt, dcnt_nxt;

   logic [AW-1:0] len_nxt, mask_nxt, bcnt_ext, grp_nxt;
   logic [AW-1:0] j_nxt, k_nxt, zeta_nxt;

   logic          v1, v2;
   logic [AW-1:0] j_d1, k_d1, j_d2, k_d2;
   logic [DW-1:0] a_reg;

   // Control state, layer, butterfly and drain counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         layer <= '0;
         bcnt  <= '0;
         dcnt  <= '0;
      end else begin
         state <= state_nxt;
         layer <= layer_nxt;
         bcnt  <= bcnt_nxt;
         dcnt  <= dcnt_nxt;
      end
   end

   // Next-state logic: 128 issues then 4 drain cycles per layer, 8 layers, one DONE cycle
   always_comb begin
      state_nxt = state;
      layer_nxt = layer;
      bcnt_nxt  = bcnt;
      dcnt_nxt  = dcnt;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = ISSUE;
               layer_nxt = '0;
               bcnt_nxt  = '0;
            end
         end
         ISSUE: begin
            if (bcnt == BCNT_LAST) begin
               state_nxt = DRAIN;
               dcnt_nxt  = '0;
            end else begin
               bcnt_nxt = bcnt + 1'b1;
            end
         end
         DRAIN: begin
            if (dcnt == 2'd3) begin
               if (layer != LAYER_LAST) begin
                  state_nxt = ISSUE;
                  layer_nxt = layer + 1'b1;
                  bcnt_nxt  = '0;
               end else begin
                  state_nxt = DONE;
               end
            end else begin
               dcnt_nxt = dcnt + 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Address of the butterfly about to issue: j is bcnt with a zero bit inserted at position l'
   always_comb begin
      bcnt_ext = {1'b0, bcnt_nxt};
      len_nxt  = AW'(HALF) >> layer_nxt;
      mask_nxt = len_nxt - 1'b1;
      grp_nxt  = bcnt_ext >> (LAYER_LAST - layer_nxt);
      j_nxt    = ((bcnt_ext & ~mask_nxt) << 1) | (bcnt_ext & mask_nxt);
      k_nxt    = j_nxt | len_nxt;
      zeta_nxt = (AW'(1) << layer_nxt) + grp_nxt;
   end

   // Registered read and zeta addresses, loaded one edge ahead of each issue cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr_j <= '0;
         rd_addr_k <= '0;
         zeta_idx  <= '0;
      end else if (state_nxt == ISSUE) begin
         rd_addr_j <= j_nxt;
         rd_addr_k <= k_nxt;
         zeta_idx  <= zeta_nxt;
      end
   end

   // Operand alignment and write-back delay line matching the butterfly latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         wr_en     <= 1'b0;
         j_d1      <= '0;
         k_d1      <= '0;
         j_d2      <= '0;
         k_d2      <= '0;
         wr_addr_j <= '0;
         wr_addr_k <= '0;
         a_reg     <= '0;
      end else begin
         v1        <= (state == ISSUE);
         j_d1      <= rd_addr_j;
         k_d1      <= rd_addr_k;
         v2        <= v1;
         j_d2      <= j_d1;
         k_d2      <= k_d1;
         a_reg     <= v1 ? rd_data_j : '0;
         wr_en     <= v2;
         wr_addr_j <= j_d2;
         wr_addr_k <= k_d2;
      end
   end

`ifdef NTT_SEQ_PERF_EN
   // Busy-cycle counter: cleared by an accepted start, held after done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_cnt <= '0;
      end else if (state == IDLE && start) begin
         cyc_cnt <= '0;
      end else if (busy) begin
         cyc_cnt <= cyc_cnt + 1'b1;
      end
   end
`endif

   // Status, bank select and gated operand/result pass-throughs
   always_comb begin
      busy      = (state == ISSUE) || (state == DRAIN);
      done      = (state == DONE);
      src_bank  = layer[0];
      bf_a      = a_reg;
      bf_b      = v1 ? rd_data_k : '0;
      bf_zeta   = v1 ? zeta_data : '0;
      wr_data_j = wr_en ? bf_u : '0;
      wr_data_k = wr_en ? bf_v : '0;
   end

endmodule

// File: tb/tb_ntt_layer_sequencer.sv
// tb_ntt_layer_sequencer
// Self-checking bench: two-bank RAM, zeta ROM and a behavioural butterfly
// around the sequencer, with a plain-loop reference NTT and a cycle-indexed
// model of the expected control/address trace.
module tb_ntt_layer_sequencer;

   localparam longint QM = 8380417;
   localparam int LAYER_CYC = 132;
   localparam int BUSY_CYC = 1056;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        busy, done, src_bank, wr_en;
   logic [7:0]  rd_addr_j, rd_addr_k, zeta_idx, wr_addr_j, wr_addr_k;
   logic [22:0] rd_data_j, rd_data_k, zeta_data;
   logic [22:0] bf_a, bf_b, bf_zeta, bf_u, bf_v;
   logic [22:0] wr_data_j, wr_data_k;
`ifdef NTT_SEQ_PERF_EN
   logic [10:0] cyc_cnt;
`endif

   logic [22:0] zrom[256];
   logic [22:0] init_poly[256];
   logic [22:0] bank0[256];
   logic [22:0] bank1[256];
   logic [22:0] ref_poly[256];
   logic        load_req;
   logic [22:0] t_reg;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ntt_layer_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .src_bank  (src_bank),
      .rd_addr_j (rd_addr_j),
      .rd_addr_k (rd_addr_k),
      .rd_data_j (rd_data_j),
      .rd_data_k (rd_data_k),
      .zeta_idx  (zeta_idx),
      .zeta_data (zeta_data),
      .bf_a      (bf_a),
      .bf_b      (bf_b),
      .bf_zeta   (bf_zeta),
      .bf_u      (bf_u),
      .bf_v      (bf_v),
`ifdef NTT_SEQ_PERF_EN
      .cyc_cnt   (cyc_cnt),
`endif
      .wr_en     (wr_en),
      .wr_addr_j (wr_addr_j),
      .wr_addr_k (wr_addr_k),
      .wr_data_j (wr_data_j),
      .wr_data_k (wr_data_k)
   );

   // Two synchronous RAM banks plus the zeta ROM; loading copies init_poly into bank 0
   always @(posedge clk) begin
      if (load_req) begin
         for (int i = 0; i < 256; i++) begin
            bank0[i] <= init_poly[i];
            bank1[i] <= 23'h0;
         end
      end else if (wr_en) begin
         if (src_bank) begin
            bank0[wr_addr_j] <= wr_data_j;
            bank0[wr_addr_k] <= wr_data_k;
         end else begin
            bank1[wr_addr_j] <= wr_data_j;
            bank1[wr_addr_k] <= wr_data_k;
         end
      end
      rd_data_j <= src_bank ? bank1[rd_addr_j] : bank0[rd_addr_j];
      rd_data_k <= src_bank ? bank1[rd_addr_k] : bank0[rd_addr_k];
      zeta_data <= zrom[zeta_idx];
   end

   // Behavioural butterfly: one multiply stage, then add/subtract, results two cycles after b/zeta
   always @(posedge clk) begin
      t_reg <= 23'((longint'(bf_b) * longint'(bf_zeta)) % QM);
      bf_u  <= 23'((longint'(bf_a) + longint'(t_reg)) % QM);
      bf_v  <= 23'((longint'(bf_a) + QM - longint'(t_reg)) % QM);
   end

   // Single comparison point: counts and reports
   task automatic checkOutput(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference forward NTT written as the textbook triple loop
   task automatic refNtt();
      longint zt, t, a;
      int kk;
      kk = 0;
      for (int i = 0; i < 256; i++) ref_poly[i] = init_poly[i];
      for (int len = 128; len > 0; len = len / 2) begin
         for (int st = 0; st < 256; st += 2 * len) begin
            kk++;
            zt = longint'(zrom[kk]);
            for (int jj = st; jj < st + len; jj++) begin
               t = (zt * longint'(ref_poly[jj + len])) % QM;
               a = longint'(ref_poly[jj]);
               ref_poly[jj + len] = 23'((a + QM - t) % QM);
               ref_poly[jj]       = 23'((a + t) % QM);
            end
         end
      end
   endtask

   // Expected addresses for butterfly b of layer l
   task automatic expAddr(input int l, input int b, output int j, output int k, output int z);
      int len, grp, off;
      len = 128 >> l;
      grp = b / len;
      off = b % len;
      j = grp * 2 * len + off;
      k = j + len;
      z = (1 << l) + grp;
   endtask

   task automatic loadPoly();
      @(negedge clk);
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   // One transform: pulse start, then check the trace cycle by cycle.
   // glitch_at re-pulses start in that busy cycle; reset_at asserts rst in that cycle and aborts.
   task automatic applyStimulus(input int glitch_at, input int reset_at);
      int l, pos, widx, ej, ek, ez;
      bit issuing, exp_wr;
      @(negedge clk);
      start = 1'b1;
      for (int idx = 1; idx <= 1060; idx++) begin
         @(negedge clk);
         start = (idx == glitch_at);
         issuing = 0;
         if (idx <= BUSY_CYC) begin
            l = (idx - 1) / LAYER_CYC;
            pos = (idx - 1) % LAYER_CYC;
            issuing = (pos < 128);
         end
         widx = idx - 3;
         exp_wr = (widx >= 1) && (widx <= BUSY_CYC) && (((widx - 1) % LAYER_CYC) < 128);
         checkOutput($sformatf("busy_c%0d", idx), busy, idx <= BUSY_CYC);
         checkOutput($sformatf("done_c%0d", idx), done, idx == BUSY_CYC + 1);
         checkOutput($sformatf("wr_en_c%0d", idx), wr_en, exp_wr);
         if (issuing) begin
            expAddr(l, pos, ej, ek, ez);
            checkOutput($sformatf("rd_j_c%0d", idx), rd_addr_j, ej);
            checkOutput($sformatf("rd_k_c%0d", idx), rd_addr_k, ek);
            checkOutput($sformatf("zeta_c%0d", idx), zeta_idx, ez);
            checkOutput($sformatf("src_bank_c%0d", idx), src_bank, l % 2);
         end
         if (exp_wr) begin
            expAddr((widx - 1) / LAYER_CYC, (widx - 1) % LAYER_CYC, ej, ek, ez);
            checkOutput($sformatf("wr_j_c%0d", idx), wr_addr_j, ej);
            checkOutput($sformatf("wr_k_c%0d", idx), wr_addr_k, ek);
         end
         if (idx == 1) begin
            checkOutput("l0_first_j", rd_addr_j, 0);
            checkOutput("l0_first_k", rd_addr_k, 128);
            checkOutput("l0_first_zeta", zeta_idx, 1);
         end
         if (idx == 3 * LAYER_CYC + 17 + 1) begin
            checkOutput("l3_b17_j", rd_addr_j, 33);
            checkOutput("l3_b17_k", rd_addr_k, 49);
            checkOutput("l3_b17_zeta", zeta_idx, 9);
         end
         if (idx == 7 * LAYER_CYC + 128) begin
            checkOutput("l7_last_j", rd_addr_j, 254);
            checkOutput("l7_last_k", rd_addr_k, 255);
            checkOutput("l7_last_zeta", zeta_idx, 255);
         end
`ifdef NTT_SEQ_PERF_EN
         if (idx == BUSY_CYC + 1 || idx == 1060)
            checkOutput($sformatf("cyc_cnt_c%0d", idx), cyc_cnt, BUSY_CYC);
`endif
         if (idx == reset_at) begin
            rst = 1'b1;
            #1;
            checkOutput("midrst_wr_en", wr_en, 0);
            checkOutput("midrst_busy", busy, 0);
            checkOutput("midrst_src_bank", src_bank, 0);
            checkOutput("midrst_zeta", zeta_idx, 0);
`ifdef NTT_SEQ_PERF_EN
            checkOutput("midrst_cyc_cnt", cyc_cnt, 0);
`endif
            @(negedge clk);
            rst = 1'b0;
            return;
         end
      end
   endtask

   task automatic checkBankAgainstRef(input string name);
      for (int i = 0; i < 256; i++)
         checkOutput($sformatf("%s_c%0d", name, i), bank0[i], ref_poly[i]);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      load_req = 1'b0;
      zrom[0] = 23'h0;
      for (int i = 1; i < 256; i++) zrom[i] = 23'($urandom_range(8380416, 0));

      repeat (3) @(negedge clk);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_wr_en", wr_en, 0);
      checkOutput("rst_src_bank", src_bank, 0);
      checkOutput("rst_rd_j", rd_addr_j, 0);
      checkOutput("rst_rd_k", rd_addr_k, 0);
      checkOutput("rst_zeta", zeta_idx, 0);
      checkOutput("rst_bf_a", bf_a, 0);
      checkOutput("rst_bf_b", bf_b, 0);
      checkOutput("rst_wr_data_j", wr_data_j, 0);
      checkOutput("rst_wr_addr_k", wr_addr_k, 0);
`ifdef NTT_SEQ_PERF_EN
      checkOutput("rst_cyc_cnt", cyc_cnt, 0);
`endif
      rst = 1'b0;

      $display("[TB] zero polynomial");
      for (int i = 0; i < 256; i++) init_poly[i] = 23'h0;
      loadPoly();
      applyStimulus(0, 0);
      for (int i = 0; i < 256; i++) checkOutput($sformatf("zero_c%0d", i), bank0[i], 0);

      $display("[TB] delta input");
      init_poly[0] = 23'd1;
      loadPoly();
      applyStimulus(0, 0);
      for (int i = 0; i < 256; i++) checkOutput($sformatf("delta_c%0d", i), bank0[i], 1);

      $display("[TB] random polynomial with start while busy");
      for (int i = 0; i < 256; i++) init_poly[i] = 23'($urandom_range(8380416, 0));
      refNtt();
      loadPoly();
      applyStimulus(500, 0);
      checkBankAgainstRef("rand");

      $display("[TB] reset during layer 4, then full transform");
      loadPoly();
      applyStimulus(0, 4 * LAYER_CYC + 50 + 1);
      for (int i = 0; i < 256; i++) init_poly[i] = 23'($urandom_range(8380416, 0));
      refNtt();
      loadPoly();
      applyStimulus(0, 0);
      checkBankAgainstRef("postrst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
